// File: rtl/baccarat_match_controller.sv
// Match-level scheduler for the baccarat hand FSM: restarts each hand, scores the
// finished hand from the win lights, tallies a fixed-length match and manages shoe reshuffles.
module baccarat_match_controller #(
  parameter int HANDS_PER_MATCH  = 9,
  parameter int SHOE_CARDS       = 52,
  parameter int RESHUFFLE_MARGIN = 6,
  parameter int HAND_TIMEOUT     = 64,
  parameter int CNT_W            = 8,
  localparam int CL_W            = $clog2(SHOE_CARDS + 1)
) (
  input  logic             slow_clock,
  input  logic             reset,
  input  logic             start,
  input  logic             next_hand,
  input  logic             hand_done,
  input  logic             player_win_light,
  input  logic             dealer_win_light,
  input  logic [2:0]       cards_used,
  input  logic             shuffle_ack,
  output logic             hand_resetb,
  output logic             shuffle_req,
  output logic [CNT_W-1:0] player_wins,
  output logic [CNT_W-1:0] dealer_wins,
  output logic [CNT_W-1:0] ties,
  output logic [CNT_W-1:0] hand_count,
  output logic [CL_W-1:0]  cards_left,
  output logic             match_over,
  output logic [1:0]       match_winner,
  output logic             fault
);

  localparam int TMO_W = $clog2(HAND_TIMEOUT + 1);

  typedef enum logic [2:0] {
    S_IDLE       = 3'd0,
    S_SHUFFLE    = 3'd1,
    S_HAND_RESET = 3'd2,
    S_HAND_RUN   = 3'd3,
    S_SCORE      = 3'd4,
    S_WAIT_NEXT  = 3'd5,
    S_MATCH_OVER = 3'd6
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] pw_q, pw_d, dw_q, dw_d, ties_q, ties_d, hc_q, hc_d;
  logic [CL_W-1:0]  cl_q, cl_d;
  logic [TMO_W-1:0] tmo_q, tmo_d;
  logic             fault_q, fault_d;
  logic             lp_q, lp_d, ld_q, ld_d;
  logic [2:0]       cu_q, cu_d;
  logic             hand_resetb_q, hand_resetb_d;
  logic             shuffle_req_q, shuffle_req_d;
  logic             match_over_q, match_over_d;
  logic [1:0]       winner_q, winner_d;
  logic             legal_s;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == {CNT_W{1'b1}}) ? v : v + {{(CNT_W-1){1'b0}}, 1'b1};
  endfunction

  function automatic logic [CL_W-1:0] sat_sub(input logic [CL_W-1:0] a, input logic [2:0] b);
    logic [CL_W-1:0] bw;
    bw = CL_W'(b);
    return (a > bw) ? a - bw : {CL_W{1'b0}};
  endfunction

  // Next-state, counter and registered-output computation
  always_comb begin
    state_d  = state_q;
    pw_d     = pw_q;
    dw_d     = dw_q;
    ties_d   = ties_q;
    hc_d     = hc_q;
    cl_d     = cl_q;
    tmo_d    = tmo_q;
    fault_d  = fault_q;
    lp_d     = lp_q;
    ld_d     = ld_q;
    cu_d     = cu_q;
    legal_s  = (lp_q | ld_q) && (cu_q >= 3'd4) && (cu_q <= 3'd6);
    case (state_q)
      S_IDLE, S_MATCH_OVER: begin
        if (start) begin
          pw_d    = {CNT_W{1'b0}};
          dw_d    = {CNT_W{1'b0}};
          ties_d  = {CNT_W{1'b0}};
          hc_d    = {CNT_W{1'b0}};
          fault_d = 1'b0;
          state_d = S_SHUFFLE;
        end else begin
          state_d = state_q;
        end
      end
      S_SHUFFLE: begin
        if (shuffle_ack) begin
          cl_d    = CL_W'(SHOE_CARDS);
          state_d = S_HAND_RESET;
        end else begin
          state_d = S_SHUFFLE;
        end
      end
      S_HAND_RESET: begin
        tmo_d   = {TMO_W{1'b0}};
        state_d = S_HAND_RUN;
      end
      S_HAND_RUN: begin
        if (hand_done) begin
          lp_d    = player_win_light;
          ld_d    = dealer_win_light;
          cu_d    = cards_used;
          state_d = S_SCORE;
        end else if (tmo_q == TMO_W'(HAND_TIMEOUT - 1)) begin
          fault_d = 1'b1;
          state_d = S_IDLE;
        end else begin
          tmo_d = tmo_q + {{(TMO_W-1){1'b0}}, 1'b1};
        end
      end
      S_SCORE: begin
        if (!legal_s) begin
          fault_d = 1'b1;
          state_d = S_IDLE;
        end else begin
          if (lp_q && !ld_q) begin
            pw_d = sat_inc(pw_q);
          end else if (ld_q && !lp_q) begin
            dw_d = sat_inc(dw_q);
          end else begin
            ties_d = sat_inc(ties_q);
          end
          hc_d    = sat_inc(hc_q);
          cl_d    = sat_sub(cl_q, cu_q);
          state_d = (hc_d == CNT_W'(HANDS_PER_MATCH)) ? S_MATCH_OVER : S_WAIT_NEXT;
        end
      end
      S_WAIT_NEXT: begin
        if (next_hand) begin
          state_d = (cl_q < CL_W'(RESHUFFLE_MARGIN)) ? S_SHUFFLE : S_HAND_RESET;
        end else begin
          state_d = S_WAIT_NEXT;
        end
      end
      default: state_d = S_IDLE;
    endcase

    // Outputs are decoded from the next state so they change together with it
    hand_resetb_d = (state_d == S_HAND_RUN) || (state_d == S_SCORE) ||
                    (state_d == S_WAIT_NEXT) || (state_d == S_MATCH_OVER);
    shuffle_req_d = (state_d == S_SHUFFLE);
    match_over_d  = (state_d == S_MATCH_OVER);
    if (state_d == S_MATCH_OVER) begin
      winner_d = (pw_d > dw_d) ? 2'b01 : ((dw_d > pw_d) ? 2'b10 : 2'b11);
    end else begin
      winner_d = 2'b00;
    end
  end

  // State and output registers with synchronous reset
  always_ff @(posedge slow_clock) begin
    if (reset) begin
      state_q       <= S_IDLE;
      pw_q          <= {CNT_W{1'b0}};
      dw_q          <= {CNT_W{1'b0}};
      ties_q        <= {CNT_W{1'b0}};
      hc_q          <= {CNT_W{1'b0}};
      cl_q          <= {CL_W{1'b0}};
      tmo_q         <= {TMO_W{1'b0}};
      fault_q       <= 1'b0;
      lp_q          <= 1'b0;
      ld_q          <= 1'b0;
      cu_q          <= 3'd0;
      hand_resetb_q <= 1'b0;
      shuffle_req_q <= 1'b0;
      match_over_q  <= 1'b0;
      winner_q      <= 2'b00;
    end else begin
      state_q       <= state_d;
      pw_q          <= pw_d;
      dw_q          <= dw_d;
      ties_q        <= ties_d;
      hc_q          <= hc_d;
      cl_q          <= cl_d;
      tmo_q         <= tmo_d;
      fault_q       <= fault_d;
      lp_q          <= lp_d;
      ld_q          <= ld_d;
      cu_q          <= cu_d;
      hand_resetb_q <= hand_resetb_d;
      shuffle_req_q <= shuffle_req_d;
      match_over_q  <= match_over_d;
      winner_q      <= winner_d;
    end
  end

  assign hand_resetb  = hand_resetb_q;
  assign shuffle_req  = shuffle_req_q;
  assign player_wins  = pw_q;
  assign dealer_wins  = dw_q;
  assign ties         = ties_q;
  assign hand_count   = hc_q;
  assign cards_left   = cl_q;
  assign match_over   = match_over_q;
  assign match_winner = winner_q;
  assign fault        = fault_q;

endmodule

// File: tb/tb_baccarat_match_controller.sv
// Directed self-checking bench for baccarat_match_controller with hand-computed expectations.
module tb_baccarat_match_controller;

  logic       slow_clock = 1'b0;
  logic       reset = 1'b1;
  logic       start = 1'b0;
  logic       next_hand = 1'b0;
  logic       hand_done = 1'b0;
  logic       player_win_light = 1'b0;
  logic       dealer_win_light = 1'b0;
  logic [2:0] cards_used = 3'd0;
  logic       shuffle_ack = 1'b0;
  logic       hand_resetb, shuffle_req, match_over, fault;
  logic [7:0] player_wins, dealer_wins, ties, hand_count;
  logic [5:0] cards_left;
  logic [1:0] match_winner;

  int n_tests = 0;
  int n_fail  = 0;

  baccarat_match_controller dut (
    .slow_clock(slow_clock), .reset(reset), .start(start), .next_hand(next_hand),
    .hand_done(hand_done), .player_win_light(player_win_light),
    .dealer_win_light(dealer_win_light), .cards_used(cards_used),
    .shuffle_ack(shuffle_ack), .hand_resetb(hand_resetb), .shuffle_req(shuffle_req),
    .player_wins(player_wins), .dealer_wins(dealer_wins), .ties(ties),
    .hand_count(hand_count), .cards_left(cards_left), .match_over(match_over),
    .match_winner(match_winner), .fault(fault)
  );

  always #5 slow_clock = ~slow_clock;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge slow_clock);
    #1;
  endtask

  // From IDLE or MATCH_OVER: start with shuffle_ack already high, ends in HAND_RUN.
  task automatic start_match();
    start = 1'b1; shuffle_ack = 1'b1;
    tick();
    start = 1'b0;
    check("sm_shuffle_req", shuffle_req, 1);
    check("sm_clear_pw", player_wins, 0);
    check("sm_clear_hc", hand_count, 0);
    check("sm_fault_clr", fault, 0);
    check("sm_winner_clr", match_winner, 0);
    tick();
    shuffle_ack = 1'b0;
    check("sm_hrb_low", hand_resetb, 0);
    check("sm_req_drop", shuffle_req, 0);
    check("sm_cards_full", cards_left, 52);
    tick();
    check("sm_hrb_release", hand_resetb, 1);
  endtask

  // From HAND_RUN: present a finished hand, wait through SCORE.
  task automatic play_hand(input logic p, input logic d, input logic [2:0] cu);
    hand_done = 1'b1; player_win_light = p; dealer_win_light = d; cards_used = cu;
    tick();
    hand_done = 1'b0; player_win_light = 1'b0; dealer_win_light = 1'b0; cards_used = 3'd0;
    tick();
  endtask

  task automatic deal_next();
    next_hand = 1'b1;
    tick();
    next_hand = 1'b0;
    tick();
  endtask

  logic [1:0] seq_a [9];
  logic [1:0] seq_b [9];
  logic [1:0] r;

  initial begin
    // 01 player, 10 dealer, 11 tie
    seq_a = '{2'b01, 2'b01, 2'b10, 2'b11, 2'b01, 2'b10, 2'b10, 2'b01, 2'b11};
    seq_b = '{2'b01, 2'b10, 2'b11, 2'b01, 2'b10, 2'b11, 2'b01, 2'b10, 2'b11};
    tick(); tick();
    reset = 1'b0;
    check("rst_hrb", hand_resetb, 0);
    check("rst_req", shuffle_req, 0);
    check("rst_pw", player_wins, 0);
    check("rst_cl", cards_left, 0);
    check("rst_mo", match_over, 0);
    check("rst_fault", fault, 0);

    // First hand, then start ignored in WAIT_NEXT, then reset mid-hand
    start_match();
    play_hand(1'b1, 1'b0, 3'd5);
    check("h1_pw", player_wins, 1);
    check("h1_hc", hand_count, 1);
    check("h1_cl", cards_left, 47);
    start = 1'b1; tick(); start = 1'b0; tick();
    check("wn_start_req", shuffle_req, 0);
    check("wn_start_pw", player_wins, 1);
    check("wn_start_hrb", hand_resetb, 1);
    next_hand = 1'b1; tick(); next_hand = 1'b0;
    check("nh_hrb_pulse", hand_resetb, 0);
    tick();
    check("nh_hrb_run", hand_resetb, 1);
    tick(); tick();
    reset = 1'b1; tick(); reset = 1'b0;
    check("mid_rst_hrb", hand_resetb, 0);
    check("mid_rst_pw", player_wins, 0);
    check("mid_rst_hc", hand_count, 0);
    check("mid_rst_fault", fault, 0);

    // Nine-hand match: P,P,D,T,P,D,D,P,T
    start_match();
    for (int i = 0; i < 9; i++) begin
      r = seq_a[i];
      play_hand(r[0], r[1], 3'd4);
      if (i < 8) deal_next();
    end
    check("m9_pw", player_wins, 4);
    check("m9_dw", dealer_wins, 3);
    check("m9_ties", ties, 2);
    check("m9_hc", hand_count, 9);
    check("m9_cl", cards_left, 16);
    check("m9_mo", match_over, 1);
    check("m9_winner", match_winner, 1);
    deal_next();
    check("mo_nh_mo", match_over, 1);
    check("mo_nh_hrb", hand_resetb, 1);
    check("mo_nh_hc", hand_count, 9);

    // Equal tally match
    start_match();
    for (int i = 0; i < 9; i++) begin
      r = seq_b[i];
      play_hand(r[0], r[1], 3'd4);
      if (i < 8) deal_next();
    end
    check("eq_pw", player_wins, 3);
    check("eq_dw", dealer_wins, 3);
    check("eq_winner", match_winner, 3);

    // Shoe depletion: eight 6-card hands leave 4 cards
    start_match();
    check("dep_winner_clr", match_winner, 0);
    for (int i = 0; i < 8; i++) begin
      play_hand(1'b1, 1'b0, 3'd6);
      if (i < 7) deal_next();
    end
    check("dep_cl4", cards_left, 4);
    next_hand = 1'b1; tick(); next_hand = 1'b0;
    check("dep_req", shuffle_req, 1);
    for (int i = 0; i < 5; i++) begin
      tick();
      check("dep_req_hold", shuffle_req, 1);
      check("dep_hrb_hold", hand_resetb, 0);
    end
    shuffle_ack = 1'b1; tick(); shuffle_ack = 1'b0;
    check("dep_cl_refill", cards_left, 52);
    check("dep_req_drop", shuffle_req, 0);
    check("dep_hrb_reset", hand_resetb, 0);
    tick();
    check("dep_hrb_run", hand_resetb, 1);
    play_hand(1'b1, 1'b0, 3'd4);
    check("dep_pw", player_wins, 9);
    check("dep_cl_end", cards_left, 48);
    check("dep_winner", match_winner, 1);

    // Timeout: 64 cycles in HAND_RUN without hand_done
    start_match();
    for (int i = 0; i < 63; i++) tick();
    check("tmo_not_yet", fault, 0);
    tick();
    check("tmo_fault", fault, 1);
    check("tmo_hrb", hand_resetb, 0);

    // Neither light lit
    start_match();
    play_hand(1'b0, 1'b0, 3'd4);
    check("nl_fault", fault, 1);
    check("nl_hc", hand_count, 0);
    check("nl_ties", ties, 0);
    check("nl_hrb", hand_resetb, 0);

    // Illegal card count
    start_match();
    play_hand(1'b1, 1'b0, 3'd4);
    check("ic_h1_pw", player_wins, 1);
    deal_next();
    play_hand(1'b1, 1'b0, 3'd7);
    check("ic_fault", fault, 1);
    check("ic_pw", player_wins, 1);
    check("ic_hc", hand_count, 1);
    check("ic_cl", cards_left, 48);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
